// File: rtl/logic_unit_pkg.sv
// Shared opcodes, counter width and per-bit gate evaluation for the pipelined logic unit.
package logic_unit_pkg;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_BUF  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    localparam int CNT_W = 16;

    // Evaluated one bit at a time so callers of any WIDTH can loop without unused padding.
    function automatic logic logic_op(input logic [2:0] op, input logic a, input logic b);
        logic r;
        case (op)
            OP_NOT:  r = ~a;
            OP_BUF:  r = a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Producer/consumer handshake bundle of the logic unit; master is the environment, slave the unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 2
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [2:0]       out_op;
    logic [CNT_W-1:0] txn_count;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, out_op, txn_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, out_op, txn_count
    );

endinterface

// File: rtl/logic_unit_pipe_slice.sv
// One elastic register slice: holds valid plus payload and refills whenever it is empty or draining.
module pipe_slice #(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    input  logic          down_ready,
    output logic          valid,
    output logic [PW-1:0] data,
    output logic          ready
);

    logic          valid_r;
    logic [PW-1:0] data_r;
    logic          ready_s;

    // Slice can take new data when empty or when its content leaves this cycle.
    always_comb begin
        ready_s = !valid_r || down_ready;
    end

    // Payload is only rewritten for a real transaction so a stalled output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= {PW{1'b0}};
        end else if (ready_s) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign ready = ready_s;

endmodule

// File: rtl/logic_unit_pipe.sv
// WIDTH-bit eight-function logic unit behind an elastic valid/ready pipeline of STAGES slices.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    logic_unit_pipe_if.slave bus
);

    localparam int PW = WIDTH + 3;

    logic [WIDTH-1:0] result_s;
    logic             valid_s [STAGES+1];
    logic [PW-1:0]    data_s  [STAGES+1];
    logic             ready_s [STAGES+1];
    logic [CNT_W-1:0] cnt_r;
    logic             pop_s;

    // Gate evaluation on the raw inputs; captured only on an accepted handshake.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            result_s[i] = logic_op(bus.op, bus.a[i], bus.b[i]);
        end
    end

    // Element 0 is the producer side, element STAGES the consumer side of the chain.
    assign valid_s[0]      = bus.in_valid;
    assign data_s[0]       = {bus.op, result_s};
    assign ready_s[STAGES] = bus.out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_slice #(
            .PW(PW)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid   (valid_s[i]),
            .up_data    (data_s[i]),
            .down_ready (ready_s[i+1]),
            .valid      (valid_s[i+1]),
            .data       (data_s[i+1]),
            .ready      (ready_s[i])
        );
    end

    assign bus.in_ready  = ready_s[0];
    assign bus.out_valid = valid_s[STAGES];
    assign bus.out_op    = data_s[STAGES][PW-1:WIDTH];
    assign bus.y         = data_s[STAGES][WIDTH-1:0];

    // Output handshake detection feeding the delivered-result counter.
    always_comb begin
        pop_s = valid_s[STAGES] && bus.out_ready;
    end

    // Saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.txn_count = cnt_r;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomized bench for logic_unit_pipe against a truth-table reference and scoreboard.
module tb_logic_unit_pipe;

    localparam int W = 8;
    localparam int S = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(W)) bus ();

    logic_unit_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cnt_m    = 0;
    int nacc;
    int nsent;
    bit free_run = 1'b1;
    bit last_acc = 1'b0;

    logic [W-1:0] yq [$];
    logic [2:0]   oq [$];
    int           tq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: per-bit truth table indexed by {a,b}.
    function automatic logic [W-1:0] ref_logic(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [3:0]   tt;
        logic [W-1:0] r;
        case (op)
            3'd0:    tt = 4'b0011;
            3'd1:    tt = 4'b1100;
            3'd2:    tt = 4'b1000;
            3'd3:    tt = 4'b1110;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b0111;
            3'd6:    tt = 4'b0001;
            default: tt = 4'b1001;
        endcase
        for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = v;
    endtask

    task automatic drive_rand(input logic v);
        drive(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), v);
    endtask

    // One clock cycle: sample at the falling edge, check, update the model, step past the rising edge.
    task automatic cycle();
        logic exp_rdy;
        int   age;
        @(negedge clk);
        if (yq.size() == 0) free_run = 1'b1;
        exp_rdy = (yq.size() < S) || bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (yq.size() == 0) begin
            chk("out_valid_empty", 32'(bus.out_valid), 32'd0);
        end else begin
            age = cyc - tq[0];
            if (free_run) chk("out_valid_latency", 32'(bus.out_valid), 32'(age >= S));
            else if (bus.out_valid === 1'b1) chk("out_valid_early", 32'(age >= S), 32'd1);
            if (bus.out_valid === 1'b1) begin
                chk("y", 32'(bus.y), 32'(yq[0]));
                chk("out_op", 32'(bus.out_op), 32'(oq[0]));
            end
        end
        chk("txn_count", 32'(bus.txn_count), 32'(cnt_m));
        last_acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        if (yq.size() != 0 && !bus.out_ready) free_run = 1'b0;
        if ((bus.out_valid === 1'b1) && bus.out_ready && yq.size() != 0) begin
            void'(yq.pop_front()); void'(oq.pop_front()); void'(tq.pop_front());
            if (cnt_m < 65535) cnt_m++;
        end
        if (last_acc) begin
            yq.push_back(ref_logic(bus.op, bus.a, bus.b));
            oq.push_back(bus.op);
            tq.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && yq.size() != 0; k++) cycle();
        chk("drain_empty", 32'(yq.size()), 32'd0);
    endtask

    initial begin
        logic [2:0] ops [4];
        ops[0] = 3'd2; ops[1] = 3'd3; ops[2] = 3'd4; ops[3] = 3'd7;

        rst_n = 1'b0;
        drive(3'd0, 8'h00, 8'h00, 1'b0);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_out_op", 32'(bus.out_op), 32'd0);
        chk("rst_txn", 32'(bus.txn_count), 32'd0);
        rst_n = 1'b1;

        // NOT over consecutive cycles with an always-ready consumer.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(3'd0, W'(k), 8'h00, 1'b1);
            cycle();
        end
        drain();
        chk("not_txn", 32'(bus.txn_count), 32'd4);

        // AND/OR/XOR/XNOR on fixed operands.
        for (int k = 0; k < 4; k++) begin
            drive(ops[k], 8'hF0, 8'h3C, 1'b1);
            cycle();
        end
        drain();

        // Backpressure: consumer stalled while five transactions are offered.
        bus.out_ready = 1'b0;
        nacc = 0;
        drive(3'd1, 8'h11, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (last_acc) begin
                nacc++;
                drive(3'd1, 8'h11 + W'(nacc), 8'h00, 1'b1);
            end
        end
        chk("bp_accepted", 32'(nacc), 32'(S));
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        nsent = nacc;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30 && nsent < 5; k++) begin
            cycle();
            if (last_acc) begin
                nsent++;
                if (nsent < 5) drive(3'd1, 8'h11 + W'(nsent), 8'h00, 1'b1);
                else bus.in_valid = 1'b0;
            end
        end
        chk("bp_total", 32'(nsent), 32'd5);
        drain();

        // Full throughput for 100 cycles.
        nacc = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            drive_rand(1'b1);
            cycle();
            if (last_acc) nacc++;
        end
        chk("tp_accepted", 32'(nacc), 32'd100);
        drain();

        // Random traffic with random stalls; producer holds inputs until accepted.
        bus.in_valid = 1'b0;
        for (int k = 0; k < 400; k++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || last_acc) drive_rand(1'($urandom_range(0, 1)));
            cycle();
        end
        drain();

        // Saturation of the delivered-result counter.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            drive_rand(1'b1);
            cycle();
        end
        drain();
        chk("sat_txn", 32'(bus.txn_count), 32'h0000FFFF);

        // Asynchronous reset with a full, stalled pipe.
        bus.out_ready = 1'b0;
        drive_rand(1'b1);
        for (int k = 0; k < S + 2; k++) begin
            cycle();
            if (last_acc) drive_rand(1'b1);
        end
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_y", 32'(bus.y), 32'd0);
        chk("arst_out_op", 32'(bus.out_op), 32'd0);
        chk("arst_txn", 32'(bus.txn_count), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        yq.delete(); oq.delete(); tq.delete();
        cnt_m = 0;
        free_run = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(3'd4, 8'hA5, 8'h5A, 1'b1);
        cycle();
        bus.in_valid = 1'b0;
        drain();
        chk("post_rst_txn", 32'(bus.txn_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
